// File: rtl/conv_calc_mc.sv
// Multi-channel KxK convolution MAC: per-channel adder trees feed a channel tree,
// then bias, optional rounding, shift, saturate/wrap and ReLU. Weights/bias are write-loaded.
module conv_calc_mc #(
  parameter int N_CH  = 3,
  parameter int K     = 5,
  parameter int DW    = 12,
  parameter int WW    = 8,
  parameter int BW    = 16,
  parameter int OW    = 14,
  parameter int SHIFT = 10,
  parameter int ROUND = 0,
  parameter int SAT   = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  input  logic [N_CH*K*K*DW-1:0]             in_data,
  input  logic                               relu_en,
  input  logic                               w_we,
  input  logic [$clog2(N_CH*K*K+1)-1:0]      w_addr,
  input  logic [BW-1:0]                      w_data,
  output logic                               w_err,
  output logic                               busy,
  output logic                               out_valid,
  output logic signed [OW-1:0]               out_data
);

  localparam int TAPS = K * K;
  localparam int NT   = N_CH * TAPS;
  localparam int AW   = DW + WW + $clog2(NT) + 2;
  localparam int TT   = $clog2(TAPS);
  localparam int TC   = $clog2(N_CH);
  localparam int LV   = TT + TC;
  localparam int LAT  = 4 + LV;
  localparam int AWID = $clog2(NT + 1);

  localparam logic signed [AW-1:0] RND =
    (ROUND != 0 && SHIFT > 0) ? (AW'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [AW-1:0] MAXV = (AW'(1) <<< (OW - 1)) - AW'(1);
  localparam logic signed [AW-1:0] MINV = -(AW'(1) <<< (OW - 1));

  logic signed [WW-1:0] weight [NT];
  logic signed [BW-1:0] bias;
  logic [LAT-1:0]       vld;
  logic [LAT-2:0]       relu_p;
  logic                 w_ok;

  logic signed [DW-1:0] s0_d [NT];
  logic signed [AW-1:0] tr   [LV+1][NT];
  logic signed [AW-1:0] tr_d [LV+1][NT];
  logic signed [AW-1:0] sp_q;
  logic signed [OW-1:0] so_val;

  assign busy      = |vld;
  assign out_valid = vld[LAT-1];
  assign w_ok      = ~busy & ~in_valid & (w_addr <= AWID'(NT));

  // Control, coefficients and the output register; everything here is cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NT; i++) weight[i] <= '0;
      bias     <= '0;
      vld      <= '0;
      relu_p   <= '0;
      w_err    <= 1'b0;
      out_data <= '0;
    end else begin
      vld    <= {vld[LAT-2:0], in_valid};
      relu_p <= {relu_p[LAT-3:0], relu_en};
      w_err  <= w_we & ~w_ok;
      if (w_we && w_ok) begin
        if (w_addr == AWID'(NT)) bias <= w_data;
        else weight[w_addr] <= w_data[WW-1:0];
      end
      if (vld[LAT-2]) out_data <= so_val;
    end
  end

  // Datapath carries no reset: stale slots are harmless because vld gates the output.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NT; i++) s0_d[i] <= in_data[i*DW +: DW];
    tr   <= tr_d;
    sp_q <= (tr[LV][0] + AW'(bias) + RND) >>> SHIFT;
  end

  // Level 0 holds the products; per-channel results collapse onto index c*TAPS,
  // and the channel tree then pairs those slots, leaving the total in index 0.
  always_comb begin
    int n;
    int nc;
    int a;
    int b;
    tr_d = '{default: '0};
    n  = TAPS;
    nc = N_CH;
    a  = 0;
    b  = 0;
    for (int i = 0; i < NT; i++) tr_d[0][i] = AW'(s0_d[i]) * AW'(weight[i]);
    for (int l = 1; l <= TT; l++) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int i = 0; i < TAPS; i++) begin
          a = c * TAPS + ((2 * i < TAPS) ? 2 * i : 0);
          b = c * TAPS + ((2 * i + 1 < TAPS) ? 2 * i + 1 : 0);
          if (2 * i + 1 < n) tr_d[l][c*TAPS+i] = tr[l-1][a] + tr[l-1][b];
          else if (2 * i < n) tr_d[l][c*TAPS+i] = tr[l-1][a];
        end
      end
      n = (n + 1) / 2;
    end
    for (int m = 1; m <= TC; m++) begin
      for (int j = 0; j < N_CH; j++) begin
        a = (2 * j < N_CH) ? 2 * j * TAPS : 0;
        b = (2 * j + 1 < N_CH) ? (2 * j + 1) * TAPS : 0;
        if (2 * j + 1 < nc) tr_d[TT+m][j*TAPS] = tr[TT+m-1][a] + tr[TT+m-1][b];
        else if (2 * j < nc) tr_d[TT+m][j*TAPS] = tr[TT+m-1][a];
      end
      nc = (nc + 1) / 2;
    end
  end

  always_comb begin
    so_val = sp_q[OW-1:0];
    if (SAT != 0) begin
      if (sp_q > MAXV) so_val = MAXV[OW-1:0];
      else if (sp_q < MINV) so_val = MINV[OW-1:0];
    end
    if (relu_p[LAT-2] && so_val[OW-1]) so_val = '0;
  end

endmodule

// File: tb/tb_conv_calc_mc.sv
// Directed and random checks of conv_calc_mc (default parameters) against an
// arithmetic reference model; results are matched by value and by arrival cycle.
module tb_conv_calc_mc;
  localparam int NT  = 75;
  localparam int LAT = 11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [NT*12-1:0]  in_data = '0;
  logic              relu_en = 1'b0;
  logic              w_we = 1'b0;
  logic [6:0]        w_addr = '0;
  logic [15:0]       w_data = '0;
  logic              w_err;
  logic              busy;
  logic              out_valid;
  logic signed [13:0] out_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int w_m [NT];
  int bias_m = 0;
  int win_m [NT];

  typedef struct {
    int val;
    int cyc;
  } exp_t;
  exp_t q[$];

  conv_calc_mc dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .relu_en(relu_en), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .w_err(w_err), .busy(busy), .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: full-precision dot product plus bias, floor shift, clamp, ReLU.
  function automatic int model(input bit relu);
    longint s;
    s = longint'(bias_m);
    for (int i = 0; i < NT; i++) s += longint'(win_m[i]) * longint'(w_m[i]);
    s = s >>> 10;
    if (s > 8191) s = 8191;
    else if (s < -8192) s = -8192;
    if (relu && s < 0) s = 0;
    return int'(s);
  endfunction

  function automatic logic [NT*12-1:0] pack();
    logic [NT*12-1:0] v;
    v = '0;
    for (int i = 0; i < NT; i++) v[i*12 +: 12] = win_m[i][11:0];
    return v;
  endfunction

  task automatic fill(input int v);
    for (int i = 0; i < NT; i++) win_m[i] = v;
  endtask

  task automatic send(input bit relu);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = pack();
    relu_en  = relu;
    e.val = model(relu);
    e.cyc = cyc + LAT;
    q.push_back(e);
  endtask

  task automatic wr(input int a, input logic [15:0] d, input bit exp_err);
    @(negedge clk);
    in_valid = 1'b0;
    w_we   = 1'b1;
    w_addr = a[6:0];
    w_data = d;
    @(negedge clk);
    w_we = 1'b0;
    chk("w_err", w_err, exp_err);
    if (!exp_err) begin
      if (a == NT) bias_m = int'($signed(d));
      else w_m[a] = int'($signed(d[7:0]));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (q.size() == 0 && !busy) break;
    end
    chk("drain_busy", busy, 0);
    chk("drain_queue", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) chk("spurious_out", out_valid, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", out_data, e.val);
        chk("out_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int last;
    for (int i = 0; i < NT; i++) begin
      w_m[i] = 0;
      win_m[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_w_err", w_err, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;

    // basic product and busy rise
    wr(0, 16'h0040, 1'b0);
    fill(0);
    win_m[0] = 16;
    send(1'b0);
    chk("busy_in_cycle", busy, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_rise", busy, 1);
    drain();
    chk("basic", out_data, 1);

    // sign and ReLU
    win_m[0] = -16;
    send(1'b0);
    drain();
    chk("negative", out_data, -1);
    send(1'b1);
    drain();
    chk("relu", out_data, 0);

    // saturation both ways
    for (int i = 0; i < NT; i++) wr(i, 16'd127, 1'b0);
    fill(2047);
    send(1'b0);
    drain();
    chk("sat_pos", out_data, 8191);
    fill(-2048);
    send(1'b0);
    drain();
    chk("sat_neg", out_data, -8192);

    // bias and floor shift
    for (int i = 0; i < NT; i++) wr(i, 16'd0, 1'b0);
    wr(NT, 16'd512, 1'b0);
    fill(1000);
    send(1'b0);
    drain();
    chk("bias_512", out_data, 0);
    wr(NT, 16'd1024, 1'b0);
    send(1'b0);
    drain();
    chk("bias_1024", out_data, 1);
    wr(NT, 16'hFFFF, 1'b0);
    send(1'b0);
    drain();
    chk("bias_minus1", out_data, -1);
    wr(NT, 16'd0, 1'b0);

    // streaming: 20 back-to-back windows
    wr(0, 16'h0040, 1'b0);
    fill(0);
    last = 0;
    for (int k = 1; k <= 20; k++) begin
      win_m[0] = 16 * k;
      send(1'b0);
      if (k > 1) chk("stream_busy", busy, 1);
      last = cyc;
    end
    @(negedge clk);
    in_valid = 1'b0;
    while (cyc < last + LAT) begin
      chk("stream_busy_hold", busy, 1);
      @(negedge clk);
    end
    chk("stream_last_valid", out_valid, 1);
    chk("stream_last_busy", busy, 1);
    chk("stream_last_data", out_data, 20);
    @(negedge clk);
    chk("stream_busy_fall", busy, 0);
    chk("stream_valid_fall", out_valid, 0);

    // write protection
    fill(0);
    win_m[0] = 16;
    send(1'b0);
    wr(0, 16'd5, 1'b1);
    @(negedge clk);
    chk("w_err_one_cycle", w_err, 0);
    drain();
    chk("weight_kept_busy", out_data, 1);
    begin
      exp_t e;
      win_m[0] = 48;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = pack();
      relu_en  = 1'b0;
      w_we     = 1'b1;
      w_addr   = 7'd0;
      w_data   = 16'd7;
      e.val = model(1'b0);
      e.cyc = cyc + LAT;
      q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      w_we = 1'b0;
      chk("w_err_in_valid", w_err, 1);
    end
    drain();
    chk("weight_kept_inv", out_data, 3);
    wr(76, 16'd9, 1'b1);
    wr(127, 16'd9, 1'b1);
    wr(NT, 16'd0, 1'b0);

    // random coefficients and windows
    for (int i = 0; i <= NT; i++) wr(i, 16'($urandom), 1'b0);
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NT; i++) win_m[i] = int'($urandom_range(0, 4095)) - 2048;
      send(1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    drain();

    // reset with windows in flight
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NT; i++) win_m[i] = int'($urandom_range(0, 4095)) - 2048;
      send(1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_data", out_data, 0);
    q.delete();
    for (int i = 0; i < NT; i++) w_m[i] = 0;
    bias_m = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("no_out_after_rst", out_valid, 0);
    end
    fill(0);
    win_m[0] = 16;
    send(1'b0);
    drain();
    chk("post_rst_tap0", out_data, 0);
    fill(2047);
    send(1'b0);
    drain();
    chk("post_rst_full", out_data, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_calc_mc.md
# conv_calc_mc

Parametrised multi-channel K×K convolution MAC engine. It is the next generation of the fixed conv1/conv2 calc blocks, and sits between a window buffer and the pooling stage. It consumes one N_CH×K×K window per valid cycle and emits one scaled, saturated output per window. Weights and bias are runtime-loadable registers instead of hard-coded ROMs, with selectable rounding, saturation and ReLU.

## Interface
- N_CH, 3: input channel count (≥1)
- K, 5: kernel side; TAPS = K*K
- DW, 12: signed input sample width
- WW, 8: signed weight width
- BW, 16: signed bias width
- OW, 14: signed output width
- SHIFT, 10: arithmetic right shift applied after bias add
- ROUND, 0: 0 = floor (plain >>>), 1 = add 2^(SHIFT-1) before shift
- SAT, 1: 1 = clamp to OW range, 0 = wrap (keep low OW bits)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  window valid
- in_data  in  N_CH*TAPS*DW  tap t of channel c at bits [(c*TAPS+t)*DW +: DW]
- relu_en  in  1  sampled with in_valid, travels with its window
- w_we  in  1  weight/bias write strobe
- w_addr  in  clog2(N_CH*TAPS+1)  0..N_CH*TAPS-1 = weight c*TAPS+t; N_CH*TAPS = bias
- w_data  in  BW  weight uses low WW bits; bias uses all BW bits
- w_err  out  1  one-cycle pulse on a rejected write
- busy  out  1  any window in flight
- out_valid  out  1  one-cycle result strobe
- out_data  out  OW  signed result

## Operation
- Accumulator width AW = DW+WW+clog2(N_CH*TAPS)+2. All sums are signed at AW with no internal overflow.
- Pipeline stages:
  - S0: register in_data and relu_en.
  - S1: N_CH*TAPS signed products.
  - TT = clog2(TAPS) per-channel pairwise adder-tree stages. An odd element passes through.
  - TC = clog2(N_CH) channel-tree stages (0 when N_CH = 1).
  - SP: add the sign-extended bias; add the rounding constant if ROUND = 1; arithmetic shift right by SHIFT.
  - SO: saturate or wrap, apply ReLU (negative result → 0), register to out_data.
- A valid shift register of matching depth tracks in_valid. busy = OR of all its bits. Invalid slots may carry garbage, but out_valid is never asserted for them.
- out_data updates only when out_valid = 1 and holds its value otherwise.
- Write rules:
  - A write is accepted only when busy = 0 and in_valid = 0 in the same cycle, and w_addr ≤ N_CH*TAPS.
  - Otherwise the write is dropped and w_err pulses high in the next cycle.
  - An accepted write affects windows whose in_valid is sampled on any later cycle.
- Reset (rst_n low, asynchronous, including mid-stream):
  - Clears all weights and the bias to 0, the valid pipe, busy, w_err, out_valid and out_data.
  - Windows in flight are discarded and produce no output after release.

## Timing
- Latency LAT = 4+TT+TC cycles: in_valid high in cycle n → out_valid high in cycle n+LAT. Defaults give 4+5+2 = 11.
- Throughput is one window per cycle. Back-to-back in_valid produces back-to-back out_valid, in order, with no bubbles.
- busy rises in the cycle after the first in_valid. It falls in the cycle after the last out_valid.
- w_err is registered: it is high in cycle m+1 for a rejected write in cycle m.
- Reset values: w_err = 0, busy = 0, out_valid = 0, out_data = 0.

## Test plan
All scenarios use default parameters.
- **Basic product:** reset; write addr 0 = 0x40; all other weights and bias 0; in_valid with ch0 tap0 = 16 and all other taps 0 → out_valid in cycle n+11, out_data = 1.
- **Sign and ReLU:** same weights, tap0 = −16 → out_data = −1; repeat with relu_en = 1 → out_data = 0.
- **Saturate vs wrap:** all 75 weights = 127, all taps = 2047 → sum 19,497,675, shifted 19040 → out_data = 8191 with SAT = 1. Build with SAT = 0 → out_data = 2656.
- **Bias and rounding:** all weights 0, bias (addr 75) = 512 → out_data = 0 with ROUND = 0. Build with ROUND = 1 → out_data = 1.
- **Streaming:** 20 consecutive in_valid windows with tap0 = 16·k (k = 1..20) and weight 0x40 → 20 contiguous out_valid cycles carrying k = 1..20 in order. busy stays high throughout and drops in the cycle after the last result.
- **Write protection and reset:**
  - A write to addr 0 while busy → w_err pulse next cycle; the weight is unchanged.
  - A write to addr 76 while idle → w_err pulse.
  - Assert rst_n low while 5 windows are in flight → out_valid and busy go 0 immediately, no result appears after release, and all weights read as 0 (a test window gives out_data = 0).
